uart_frame_parser: RTL and testbench

Downstream consumer of the UART receiver's byte output (data byte plus level valid flag). Hunts for a sync byte, then collects a length-prefixed payload and checks an 8-bit additive checksum. Good frames are released on a ready/valid byte stream with a last marker; bad frames are dropped and flagged. Sits between the RS-232 receiver and the command/control logic.

---
 rtl/uart_frame_pkg.sv | 15 +
 rtl/uart_frame_buf.sv | 23 ++
 rtl/uart_frame_parser.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// State encoding plus the default sync marker and byte/checksum widths.
package uart_frame_pkg;
   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_EMIT
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         CHK_W             = 8;
   localparam int         BYTE_W            = 8;
endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x byte register file, synchronous write, combinational read.
// Storage is not reset; contents are only read after being written for the current frame.
module uart_frame_buf
   import uart_frame_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [BYTE_W-1:0] rdata
);
   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_frame_parser.sv
// Hunts for SYNC, collects a length-prefixed payload, verifies an additive checksum and
// releases good frames on a valid/ready byte stream; bad frames are dropped with a pulse.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 520800
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       frame_ok,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       busy
);
   localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 1);

   state_t             state, state_nxt;
   logic [7:0]         len_q, len_nxt;
   logic [CHK_W-1:0]   sum_q, sum_nxt;
   logic [7:0]         idx_q, idx_nxt;
   logic [7:0]         emit_q, emit_nxt;
   logic [TW-1:0]      cnt_q, cnt_nxt;
   logic               rx_valid_d;
   logic               ok_q, ok_nxt;
   logic               chk_q, chk_nxt;
   logic               lenerr_q, lenerr_nxt;
   logic               to_q, to_nxt;
   logic               ovr_q, ovr_nxt;
   logic               buf_we;
   logic [BYTE_W-1:0]  buf_rdata;
   logic               stb;
   logic               tc;
   logic [7:0]         last_idx;

   // rx_valid is a level that stays high after each byte, so only its rising edge is a byte
   assign stb      = rx_valid & ~rx_valid_d;
   assign tc       = (cnt_q == TC_VAL);
   assign last_idx = len_q - 8'd1;

   uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx_q[AW-1:0]),
      .wdata (rx_data),
      .raddr (emit_q[AW-1:0]),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_SYNC;
         len_q      <= '0;
         sum_q      <= '0;
         idx_q      <= '0;
         emit_q     <= '0;
         cnt_q      <= '0;
         rx_valid_d <= 1'b0;
         ok_q       <= 1'b0;
         chk_q      <= 1'b0;
         lenerr_q   <= 1'b0;
         to_q       <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         len_q      <= len_nxt;
         sum_q      <= sum_nxt;
         idx_q      <= idx_nxt;
         emit_q     <= emit_nxt;
         cnt_q      <= cnt_nxt;
         rx_valid_d <= rx_valid;
         ok_q       <= ok_nxt;
         chk_q      <= chk_nxt;
         lenerr_q   <= lenerr_nxt;
         to_q       <= to_nxt;
         ovr_q      <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      len_nxt    = len_q;
      sum_nxt    = sum_q;
      idx_nxt    = idx_q;
      emit_nxt   = emit_q;
      ok_nxt     = 1'b0;
      chk_nxt    = 1'b0;
      lenerr_nxt = 1'b0;
      to_nxt     = 1'b0;
      ovr_nxt    = 1'b0;
      buf_we     = 1'b0;

      if (stb || state == S_SYNC || state == S_EMIT) cnt_nxt = '0;
      else                                           cnt_nxt = cnt_q + 1'b1;

      case (state)
         S_SYNC: begin
            if (stb && rx_data == SYNC_BYTE) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (stb) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  lenerr_nxt = 1'b1;
                  state_nxt  = S_SYNC;
               end else begin
                  len_nxt   = rx_data;
                  sum_nxt   = rx_data;
                  idx_nxt   = '0;
                  state_nxt = S_PAYLOAD;
               end
            end else if (tc) begin
               to_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_SYNC;
            end
         end
         S_PAYLOAD: begin
            if (stb) begin
               buf_we  = 1'b1;
               sum_nxt = sum_q + rx_data;
               idx_nxt = idx_q + 8'd1;
               if (idx_q == last_idx) state_nxt = S_CHK;
            end else if (tc) begin
               to_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_SYNC;
            end
         end
         S_CHK: begin
            if (stb) begin
               if (rx_data == sum_q) begin
                  ok_nxt    = 1'b1;
                  emit_nxt  = '0;
                  state_nxt = S_EMIT;
               end else begin
                  chk_nxt   = 1'b1;
                  state_nxt = S_SYNC;
               end
            end else if (tc) begin
               to_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_SYNC;
            end
         end
         S_EMIT: begin
            // no buffering for a second frame: bytes arriving now are lost
            if (stb) ovr_nxt = 1'b1;
            if (m_ready) begin
               emit_nxt = emit_q + 8'd1;
               if (emit_q == last_idx) state_nxt = S_SYNC;
            end
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   assign m_valid     = (state == S_EMIT);
   assign m_data      = m_valid ? buf_rdata : 8'd0;
   assign m_last      = m_valid && (emit_q == last_idx);
   assign busy        = (state != S_SYNC);
   assign frame_ok    = ok_q;
   assign err_chk     = chk_q;
   assign err_len     = lenerr_q;
   assign err_timeout = to_q;
   assign err_overrun = ovr_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench: byte-level stimulus against a queue-based frame grammar model.
module tb_uart_frame_parser;
   localparam int MAXL = 16;
   localparam int TO   = 1000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic       m_last;
   logic       frame_ok, err_chk, err_len, err_timeout, err_overrun, busy;

   always #5 clk = ~clk;

   uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
      .err_timeout(err_timeout), .err_overrun(err_overrun), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_stb = 0;
   int rdy_mode = 0;

   // observed
   logic [8:0] got_q[$];
   int         got_cyc[$];
   int n_ok, n_chk, n_len, n_to, n_ovr, n_valid, ok_cyc, to_cyc;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   // model
   logic [7:0] mq[$];
   logic [8:0] exp_q[$];
   int e_ok, e_chk, e_len, e_to, e_ovr;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0: m_ready = 1'b1;
         1: m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: protocol invariants every cycle, plus collection of transfers and pulses
   initial forever begin
      @(negedge clk);
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         checks++;
         if ($countones({frame_ok, err_chk, err_len, err_timeout, err_overrun}) > 1) begin
            errors++;
            $display("FAIL pulse_exclusive cyc=%0d pulses=%b expected at most one", cyc,
                     {frame_ok, err_chk, err_len, err_timeout, err_overrun});
         end
         if (!m_valid) begin
            checks++;
            if (m_data !== 8'h00 || m_last !== 1'b0) begin
               errors++;
               $display("FAIL idle_zero cyc=%0d data=%h last=%b expected 00/0", cyc, m_data, m_last);
            end
         end
         if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
               errors++;
               $display("FAIL stall_hold cyc=%0d valid=%b data=%h last=%b expected 1/%h/%b",
                        cyc, m_valid, m_data, m_last, prev_data, prev_last);
            end
         end
         if (frame_ok)    begin n_ok++; ok_cyc = cyc; end
         if (err_chk)     n_chk++;
         if (err_len)     n_len++;
         if (err_timeout) begin n_to++; to_cyc = cyc; end
         if (err_overrun) n_ovr++;
         if (m_valid)     n_valid++;
         if (m_valid && m_ready) begin
            got_q.push_back({m_last, m_data});
            got_cyc.push_back(cyc);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_all();
      got_q.delete(); got_cyc.delete(); exp_q.delete(); mq.delete();
      n_ok = 0; n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0; n_valid = 0;
      e_ok = 0; e_chk = 0; e_len = 0; e_to = 0; e_ovr = 0;
   endtask

   // Grammar model: SYNC, LEN, LEN bytes, CHK where CHK = (LEN + sum) mod 256
   task automatic model_feed(input logic [7:0] b);
      bit progress;
      int l, acc;
      mq.push_back(b);
      progress = 1'b1;
      while (progress) begin
         progress = 1'b0;
         if (mq.size() > 0 && mq[0] != 8'hA5) begin
            void'(mq.pop_front());
            progress = 1'b1;
         end else if (mq.size() >= 2) begin
            l = int'(mq[1]);
            if (l == 0 || l > MAXL) begin
               e_len++;
               void'(mq.pop_front());
               void'(mq.pop_front());
               progress = 1'b1;
            end else if (mq.size() >= l + 3) begin
               acc = l;
               for (int i = 0; i < l; i++) acc += int'(mq[2 + i]);
               if (int'(mq[l + 2]) == acc % 256) begin
                  e_ok++;
                  for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), mq[2 + i]});
               end else begin
                  e_chk++;
               end
               for (int i = 0; i < l + 3; i++) void'(mq.pop_front());
               progress = 1'b1;
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 last_stb = cyc;
      #1;
   endtask

   task automatic tx(input logic [7:0] b);
      send_byte(b, $urandom_range(1, 3));
      model_feed(b);
   endtask

   task automatic send_frame(input int len, input bit good);
      int acc;
      logic [7:0] b;
      tx(8'hA5);
      tx(8'(len));
      if (len >= 1 && len <= MAXL) begin
         acc = len;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            acc += int'(b);
            tx(b);
         end
         b = 8'(acc % 256);
         if (!good) b = b ^ 8'($urandom_range(1, 255));
         tx(b);
      end
   endtask

   task automatic wait_idle(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (got_q.size() >= exp_q.size() && !busy) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      checks++; if (m_valid !== 1'b0)     begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_data !== 8'h00)     begin errors++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
      checks++; if (m_last !== 1'b0)      begin errors++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if ({frame_ok, err_chk, err_len, err_timeout, err_overrun} !== 5'b0) begin
         errors++; $display("FAIL rst_pulses got=%b exp=00000", {frame_ok, err_chk, err_len, err_timeout, err_overrun});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_good_frame();
      bit to;
      int chk_cyc;
      clear_all(); rdy_mode = 0;
      tx(8'hA5); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h69);
      chk_cyc = last_stb;
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL good_drain timed out got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
      checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin
         errors++; $display("FAIL good_count got=%0d exp=3 (model %0d)", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (ok_cyc != chk_cyc) begin errors++; $display("FAIL good_ok_latency got=%0d exp=%0d", ok_cyc, chk_cyc); end
      if (got_cyc.size() == 3) begin
         checks++;
         if (got_cyc[0] != chk_cyc || got_cyc[1] != chk_cyc + 1 || got_cyc[2] != chk_cyc + 2) begin
            errors++; $display("FAIL good_timing got=%0d,%0d,%0d exp=%0d..+2", got_cyc[0], got_cyc[1], got_cyc[2], chk_cyc);
         end
      end
      checks++; if (n_ok != 1 || n_chk + n_len + n_to + n_ovr != 0) begin
         errors++; $display("FAIL good_pulses got ok=%0d err=%0d exp ok=1 err=0", n_ok, n_chk + n_len + n_to + n_ovr);
      end
   endtask

   task automatic test_garbage();
      bit to;
      clear_all(); rdy_mode = 0;
      tx(8'h00); tx(8'hFF); tx(8'h7E); tx(8'hA5); tx(8'h01); tx(8'h7E); tx(8'h7F);
      wait_idle(to);
      checks++; if (to) begin errors++; $display("FAIL garbage_drain timed out got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      checks++; if (got_q.size() != 1 || got_q[0] !== 9'h17E) begin
         errors++; $display("FAIL garbage_out got=%0d bytes first=%h exp=1 byte 17e", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
      end
      checks++; if (n_ok != e_ok || n_ok != 1 || n_chk + n_len + n_to + n_ovr != 0) begin
         errors++; $display("FAIL garbage_pulses got ok=%0d err=%0d exp ok=%0d err=0", n_ok, n_chk + n_len + n_to + n_ovr, e_ok);
      end
   endtask

   task automatic test_errors();
      bit to;
      clear_all(); rdy_mode = 0;
      tx(8'hA5); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h6A);
      wait_idle(to);
      checks++; if (n_chk != 1 || n_chk != e_chk) begin errors++; $display("FAIL bad_chk got=%0d exp=%0d", n_chk, e_chk); end
      tx(8'hA5); tx(8'h00);
      wait_idle(to);
      tx(8'hA5); tx(8'h11);
      wait_idle(to);
      checks++; if (n_len != 2 || n_len != e_len) begin errors++; $display("FAIL bad_len got=%0d exp=%0d", n_len, e_len); end
      checks++; if (n_valid != 0 || n_ok != 0) begin errors++; $display("FAIL bad_no_output got valid=%0d ok=%0d exp 0/0", n_valid, n_ok); end
      // longest legal frame
      send_frame(MAXL, 1'b1);
      wait_idle(to);
      checks++; if (to || got_q.size() != exp_q.size() || exp_q.size() != MAXL) begin
         errors++; $display("FAIL maxlen_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxlen_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_ok != 1) begin errors++; $display("FAIL maxlen_ok got=%0d exp=1", n_ok); end
   endtask

   task automatic test_timeout();
      bit to;
      int st;
      clear_all(); rdy_mode = 0;
      tx(8'hA5); tx(8'h02); tx(8'h11);
      st = last_stb;
      rx_valid = 1'b0;
      for (int i = 0; i < TO + 100 && n_to == 0; i++) tick();
      tick();
      checks++; if (n_to != 1) begin errors++; $display("FAIL timeout_count got=%0d exp=1", n_to); end
      checks++; if (to_cyc - st != TO) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", to_cyc - st, TO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      checks++; if (n_ok + n_chk + n_len + n_ovr != 0) begin errors++; $display("FAIL timeout_other got=%0d exp=0", n_ok + n_chk + n_len + n_ovr); end
      clear_all();
      tx(8'hA5); tx(8'h01); tx(8'h7E); tx(8'h7F);
      wait_idle(to);
      checks++; if (to || n_ok != 1 || got_q.size() != 1 || got_q[0] !== 9'h17E) begin
         errors++; $display("FAIL timeout_recover got ok=%0d bytes=%0d exp ok=1 bytes=1 (17e)", n_ok, got_q.size());
      end
   endtask

   task automatic test_backpressure_overrun();
      bit to;
      clear_all(); rdy_mode = 1;
      tx(8'hA5); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h69);
      send_byte(8'h55, 1);
      e_ovr = 1;
      wait_idle(to);
      checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_ovr != e_ovr || n_ok != e_ok) begin
         errors++; $display("FAIL bp_pulses got ovr=%0d ok=%0d exp ovr=%0d ok=%0d", n_ovr, n_ok, e_ovr, e_ok);
      end
      rdy_mode = 0;
      tick();
   endtask

   task automatic test_reset_midframe();
      bit to;
      clear_all(); rdy_mode = 0;
      tx(8'hA5); tx(8'h03); tx(8'h11);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      #1 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outs got busy=%b v=%b d=%h l=%b exp 0/0/00/0", busy, m_valid, m_data, m_last);
      end
      checks++; if ({frame_ok, err_chk, err_len, err_timeout, err_overrun} !== 5'b0) begin
         errors++; $display("FAIL mid_reset_pulses got=%b exp=00000", {frame_ok, err_chk, err_len, err_timeout, err_overrun});
      end
      rx_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      clear_all();
      tick();
      tx(8'hA5); tx(8'h01); tx(8'h7E); tx(8'h7F);
      wait_idle(to);
      checks++; if (to || n_ok != 1 || got_q.size() != 1 || got_q[0] !== 9'h17E) begin
         errors++; $display("FAIL mid_recover got ok=%0d bytes=%0d exp ok=1 bytes=1 (17e)", n_ok, got_q.size());
      end
      checks++; if (n_chk + n_len + n_to + n_ovr != 0) begin errors++; $display("FAIL mid_no_err got=%0d exp=0", n_chk + n_len + n_to + n_ovr); end
   endtask

   task automatic test_random();
      bit to;
      bit any_to;
      logic [7:0] g;
      clear_all(); rdy_mode = 2;
      any_to = 1'b0;
      for (int f = 0; f < 30; f++) begin
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            tx(g);
         end
         send_frame($urandom_range(0, MAXL + 2), ($urandom_range(0, 3) != 0));
         wait_idle(to);
         if (to) any_to = 1'b1;
      end
      checks++; if (any_to) begin errors++; $display("FAIL rand_drain timed out got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_ok != e_ok || n_chk != e_chk || n_len != e_len || n_to != 0 || n_ovr != 0) begin
         errors++; $display("FAIL rand_pulses got ok=%0d chk=%0d len=%0d to=%0d ovr=%0d exp %0d/%0d/%0d/0/0",
                            n_ok, n_chk, n_len, n_to, n_ovr, e_ok, e_chk, e_len);
      end
      rdy_mode = 0;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_garbage();
      test_errors();
      test_timeout();
      test_backpressure_overrun();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
